dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width.
REQ-002 SHALL have parameter DM_ADDRESS, default 9, data-memory address width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, legal 1..15, denied debug cycles before a forced debug grant.
REQ-004 SHALL have port clk  in  1  the one clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports p_rd, p_wr  in  1 each  pipeline MEM-stage read and write requests.
REQ-007 SHALL have ports p_addr  in  DM_ADDRESS, p_wdata  in  DATA_W, p_func3  in  3  pipeline access address, data and size.
REQ-008 SHALL have ports p_rdata  out  DATA_W, p_stall  out  1  pipeline read data and MEM-stage hold request.
REQ-009 SHALL have ports d_req, d_we  in  1 each  debug access request and write select.
REQ-010 SHALL have ports d_addr  in  DM_ADDRESS, d_wdata  in  DATA_W  debug address and write data; debug accesses are always word (func3 = 3'b010).
REQ-011 SHALL have ports d_gnt, d_rvalid  out  1 each, d_rdata  out  DATA_W  debug grant, read-valid and read data.
REQ-012 SHALL have ports m_rd, m_wr  out  1 each, m_addr  out  DM_ADDRESS, m_wdata  out  DATA_W, m_func3  out  3  data-memory port.
REQ-013 SHALL have port m_rdata  in  DATA_W  memory read data, valid in the same cycle as m_rd.

Function
REQ-014 SHALL implement FSM states P_OWN, D_OWN, D_RESP, where p_active = p_rd | p_wr.
REQ-015 In P_OWN and D_RESP, SHALL drive the m_* outputs from the p_* inputs and set p_rdata = m_rdata.
REQ-016 In D_OWN, SHALL drive m_rd = ~d_we, m_wr = d_we, m_addr = d_addr, m_wdata = d_wdata, m_func3 = 3'b010.
REQ-017 In D_OWN, SHALL assert d_gnt = 1, and SHALL assert p_stall = p_active combinationally so the pipeline retries next cycle.
REQ-018 SHALL drive p_stall = 0 in P_OWN and D_RESP.
REQ-019 SHALL keep a 4-bit starve_cnt, incremented each P_OWN/D_RESP cycle with d_req & p_active, saturating at STARVE_MAX.
REQ-020 SHALL clear starve_cnt on entry to D_OWN and whenever d_req = 0.
REQ-021 SHALL transition P_OWN -> D_OWN when d_req & (~p_active | starve_cnt == STARVE_MAX); otherwise P_OWN -> P_OWN.
REQ-022 SHALL transition D_OWN -> D_RESP unconditionally, making every debug access exactly one memory cycle.
REQ-023 SHALL apply the REQ-021 condition for D_RESP -> D_OWN, else D_RESP -> P_OWN.
REQ-024 Back-to-back debug grants SHALL therefore require an idle pipeline or a renewed starvation count.
REQ-025 SHALL register d_rdata <= m_rdata at the end of a D_OWN read, and SHALL assert d_rvalid for exactly the D_RESP cycle following a read.
REQ-026 SHALL hold d_rdata between reads and SHALL NOT assert d_rvalid after a debug write.
REQ-027 Debug requester SHALL hold d_req, d_we, d_addr and d_wdata stable until d_gnt; d_req deasserted before grant SHALL simply withdraw the request.
REQ-028 On same-address conflict, the debug access SHALL complete first, so a stalled pipeline read retried after a debug write returns the debug data.
REQ-029 p_rd and p_wr both high is illegal; if it occurs, SHALL pass both through unchanged.

Reset
REQ-030 While reset = 0, SHALL force state to P_OWN, starve_cnt = 0, d_rdata = 0, d_gnt = 0, d_rvalid = 0, and p_stall = 0.
REQ-031 While reset = 0, SHALL pass the p_* inputs through to the m_* outputs.
REQ-032 On reset assertion during D_OWN, SHALL abort the in-flight debug access with no d_rvalid, while any memory write already committed at an earlier edge stands.
REQ-033 After reset release, SHALL begin arbitration on the first rising clk edge.

Verification
REQ-034 Idle pipeline, d_req=1, d_we=0, d_addr=0x010, mem[0x010]=0xCAFEF00D -> d_gnt in cycle 1; d_rvalid=1 with d_rdata=0xCAFEF00D in cycle 2; p_stall=0 throughout.
REQ-035 p_rd held high continuously, d_req held high with STARVE_MAX=8 -> d_gnt first asserted after 8 denied cycles, p_stall=1 that cycle only, then starve_cnt=0.
REQ-036 Debug write 0x12345678 to 0x020 forced while the pipeline reads 0x020 -> p_stall=1; next cycle p_rdata=0x12345678.
REQ-037 Idle pipeline, debug issues three reads back to back -> grants in cycles 1, 3 and 5 (D_OWN/D_RESP alternating), each followed by d_rvalid.
REQ-038 reset asserted mid-cycle during D_OWN -> d_gnt, d_rvalid and p_stall drop immediately; state P_OWN after release; no d_rvalid for the aborted read.
REQ-039 d_req pulsed for 3 cycles under continuous p_wr, then dropped -> no grant, starve_cnt returns to 0, pipeline never stalled.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-cycle data-memory port between the pipeline MEM stage and
// a debug requester. The pipeline owns the port by default. A debug request
// takes the port for exactly one cycle in two cases:
//   - the pipeline is idle that cycle, or
//   - the debug request has been starved for STARVE_MAX pipeline cycles.
// While debug owns the port, an active pipeline access is stalled and retried
// on the following cycle.
//
// Debug handshake (req/gnt): the requester raises d_req together with d_we,
// d_addr and d_wdata, and holds all four stable until it sees d_gnt = 1. The
// access is performed in the d_gnt cycle. Dropping d_req before d_gnt
// withdraws the request. A read returns d_rdata with d_rvalid = 1 in the cycle
// after d_gnt; writes never produce d_rvalid.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   p_rd, p_wr             pipeline read / write request
//   p_addr, p_wdata,       pipeline address, write data and access size
//   p_func3
//   p_rdata, p_stall       pipeline read data, MEM-stage hold request
//   d_req, d_we            debug request, write select
//   d_addr, d_wdata        debug address and write data (always word access)
//   d_gnt, d_rvalid,       debug grant, read-valid and read data
//   d_rdata
//   m_rd, m_wr, m_addr,    data-memory port
//   m_wdata, m_func3
//   m_rdata                memory read data, valid in the same cycle as m_rd
//   dbg_state              current arbiter state (P_OWN=0, D_OWN=1, D_RESP=2)
//   dbg_starve_cnt         current debug starvation count
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p_rd,
    input  logic                  p_wr,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_func3,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_rd,
    output logic                  m_wr,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_func3,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic [1:0]            dbg_state,
    output logic [3:0]            dbg_starve_cnt
);

    typedef enum logic [1:0] {
        P_OWN  = 2'd0,
        D_OWN  = 2'd1,
        D_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] FUNC3_WORD = 3'b010;

    state_t     state;
    logic [3:0] starve_cnt;

    logic p_active;
    logic debug_cycle;
    logic take_debug;

    assign p_active    = p_rd | p_wr;
    assign debug_cycle = (state == D_OWN);

    // Debug wins immediately when the pipeline leaves the port free, or once
    // it has been denied often enough to hit the starvation limit.
    assign take_debug = d_req & (~p_active | (starve_cnt == STARVE_LIM));

    // Memory port mux. Outside D_OWN (including while reset is held, since
    // state is forced to P_OWN) the pipeline drives the port directly; an
    // illegal p_rd & p_wr combination is passed through unchanged.
    always_comb begin
        m_rd    = p_rd;
        m_wr    = p_wr;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        m_func3 = p_func3;
        if (debug_cycle) begin
            m_rd    = ~d_we;
            m_wr    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_func3 = FUNC3_WORD;
        end
    end

    // Read data reaches the pipeline whenever it owns the port. In D_OWN the
    // pipeline is stalled and ignores this value.
    assign p_rdata = m_rdata;

    // Combinational so the MEM stage holds in the very cycle it loses the port.
    assign p_stall = debug_cycle & p_active;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= P_OWN;
            starve_cnt <= 4'd0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            case (state)
                P_OWN, D_RESP: begin
                    d_rvalid <= 1'b0;
                    if (take_debug) begin
                        state      <= D_OWN;
                        d_gnt      <= 1'b1;
                        starve_cnt <= 4'd0;
                    end else begin
                        state <= P_OWN;
                        d_gnt <= 1'b0;
                        // A waiting request that was not taken implies an
                        // active pipeline, so it was a denied cycle.
                        if (!d_req) begin
                            starve_cnt <= 4'd0;
                        end else if (p_active && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end

                D_OWN: begin
                    // Every debug access is exactly one memory cycle.
                    state      <= D_RESP;
                    d_gnt      <= 1'b0;
                    starve_cnt <= 4'd0;
                    d_rvalid   <= ~d_we;
                    if (!d_we) begin
                        d_rdata <= m_rdata;
                    end
                end

                default: begin
                    state      <= P_OWN;
                    d_gnt      <= 1'b0;
                    d_rvalid   <= 1'b0;
                    starve_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. A behavioural memory answers the DUT's m_* port.
// A reference model tracks, per cycle, who should own the port, the debug
// starvation count, expected read data (ref_mem) and outstanding debug reads
// (exp_q). Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;
    localparam int STARVE_MAX = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                  p_rd, p_wr;
    logic [DM_ADDRESS-1:0] p_addr;
    logic [DATA_W-1:0]     p_wdata;
    logic [2:0]            p_func3;
    logic [DATA_W-1:0]     p_rdata;
    logic                  p_stall;
    logic                  d_req, d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt, d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  m_rd, m_wr;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_func3;
    logic [DATA_W-1:0]     m_rdata;
    logic [1:0]            dbg_state;
    logic [3:0]            dbg_starve_cnt;

    dmem_arbiter #(
        .DATA_W    (DATA_W),
        .DM_ADDRESS(DM_ADDRESS),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p_rd          (p_rd),
        .p_wr          (p_wr),
        .p_addr        (p_addr),
        .p_wdata       (p_wdata),
        .p_func3       (p_func3),
        .p_rdata       (p_rdata),
        .p_stall       (p_stall),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .m_rd          (m_rd),
        .m_wr          (m_wr),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_func3       (m_func3),
        .m_rdata       (m_rdata),
        .dbg_state     (dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- behavioural memory ----------------
    logic [DATA_W-1:0] mem [0:511];
    assign m_rdata = mem[m_addr];

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W-1:0] ref_mem [0:511];
    logic [DATA_W-1:0] exp_q[$];
    bit                mdl_gnt;      // debug owns the port this cycle
    bit                mdl_rvalid;   // debug read data due this cycle
    int                mdl_starve;   // denied cycles of the waiting request
    logic [DATA_W-1:0] mdl_drdata;   // last debug read value

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        p_rd  = 1'b0;
        p_wr  = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic model_reset();
        mdl_gnt    = 1'b0;
        mdl_rvalid = 1'b0;
        mdl_starve = 0;
        mdl_drdata = '0;
        exp_q.delete();
    endtask

    // One clock cycle: called at posedge+1 with inputs already driven.
    // Checks at the falling edge, advances the model, returns at posedge+1.
    // 'granted' reports the d_gnt the DUT showed in this cycle.
    task automatic step(output bit granted);
        bit                p_act;
        bit                take;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        p_act   = p_rd | p_wr;
        granted = d_gnt;

        check("d_gnt", 64'(d_gnt), 64'(mdl_gnt));
        check("p_stall", 64'(p_stall), 64'(mdl_gnt & p_act));
        check("starve_cnt", 64'(dbg_starve_cnt), 64'(mdl_starve));
        if (mdl_gnt) begin
            check("m_rd_dbg", 64'(m_rd), 64'(!d_we));
            check("m_wr_dbg", 64'(m_wr), 64'(d_we));
            check("m_addr_dbg", 64'(m_addr), 64'(d_addr));
            check("m_wdata_dbg", 64'(m_wdata), 64'(d_wdata));
            check("m_func3_dbg", 64'(m_func3), 64'(3'b010));
        end else begin
            check("m_rd_p", 64'(m_rd), 64'(p_rd));
            check("m_wr_p", 64'(m_wr), 64'(p_wr));
            check("m_addr_p", 64'(m_addr), 64'(p_addr));
            check("m_wdata_p", 64'(m_wdata), 64'(p_wdata));
            check("m_func3_p", 64'(m_func3), 64'(p_func3));
            if (p_rd) check("p_rdata", 64'(p_rdata), 64'(ref_mem[p_addr]));
        end
        check("d_rvalid", 64'(d_rvalid), 64'(mdl_rvalid));
        if (mdl_rvalid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL d_rvalid_q: observed read-valid expected no outstanding read");
            end else begin
                e = exp_q.pop_front();
                check("d_rdata_rvalid", 64'(d_rdata), 64'(e));
            end
        end
        check("d_rdata_hold", 64'(d_rdata), 64'(mdl_drdata));

        // environment memory follows whatever the DUT put on the port
        if (m_wr) mem[m_addr] = m_wdata;

        // reference: one owner per cycle, one-cycle debug access
        if (mdl_gnt) begin
            if (d_we) begin
                ref_mem[d_addr] = d_wdata;
            end else begin
                mdl_drdata = ref_mem[d_addr];
                exp_q.push_back(mdl_drdata);
            end
            mdl_rvalid = !d_we;
            mdl_gnt    = 1'b0;
            mdl_starve = 0;
        end else begin
            if (p_wr) ref_mem[p_addr] = p_wdata;
            mdl_rvalid = 1'b0;
            take = d_req && (!p_act || mdl_starve == STARVE_MAX);
            if (take) begin
                mdl_gnt    = 1'b1;
                mdl_starve = 0;
            end else if (!d_req) begin
                mdl_starve = 0;
            end else if (mdl_starve < STARVE_MAX) begin
                mdl_starve = mdl_starve + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit g;
        int first;
        int ngr;
        int gcyc [0:2];
        int op;

        reset   = 1'b0;
        p_rd    = 1'b1;
        p_wr    = 1'b0;
        p_addr  = 9'h005;
        p_wdata = 32'h0;
        p_func3 = 3'b010;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        model_reset();

        // reset state and pass-through while reset is held
        #12;
        check("rst_d_gnt", 64'(d_gnt), 64'(0));
        check("rst_d_rvalid", 64'(d_rvalid), 64'(0));
        check("rst_p_stall", 64'(p_stall), 64'(0));
        check("rst_d_rdata", 64'(d_rdata), 64'(0));
        check("rst_starve", 64'(dbg_starve_cnt), 64'(0));
        check("rst_m_rd", 64'(m_rd), 64'(1));
        check("rst_m_addr", 64'(m_addr), 64'(9'h005));
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        @(posedge clk);
        #1;

        // idle pipeline, single debug read
        mem[9'h010]     = 32'hCAFEF00D;
        ref_mem[9'h010] = 32'hCAFEF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010;
        step(g);
        check("rd_no_gnt_c0", 64'(g), 64'(0));
        step(g);
        check("rd_gnt_c1", 64'(g), 64'(1));
        d_req = 1'b0;
        #3;
        check("rd_rvalid_c2", 64'(d_rvalid), 64'(1));
        check("rd_data_c2", 64'(d_rdata), 64'(32'hCAFEF00D));
        step(g);
        step(g);

        // continuous pipeline reads starve a debug read
        p_rd = 1'b1; p_addr = 9'h041; p_func3 = 3'b010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
        first = -1;
        for (int c = 0; c < 30; c++) begin
            step(g);
            if (g) begin
                first = c;
                break;
            end
        end
        check("starve_gnt_cycle", 64'(first), 64'(STARVE_MAX + 1));
        d_req = 1'b0;
        step(g);
        step(g);
        set_idle();
        step(g);

        // forced debug write on the address the pipeline is reading
        p_rd = 1'b1; p_addr = 9'h020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h020; d_wdata = 32'h12345678;
        first = -1;
        for (int c = 0; c < 30; c++) begin
            step(g);
            if (g) begin
                first = c;
                break;
            end
        end
        check("wr_forced_gnt", 64'(first), 64'(STARVE_MAX + 1));
        d_req = 1'b0;
        #3;
        check("wr_retry_rdata", 64'(p_rdata), 64'(32'h12345678));
        check("wr_no_rvalid", 64'(d_rvalid), 64'(0));
        step(g);
        set_idle();
        step(g);

        // three back-to-back debug reads, idle pipeline
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h030;
        ngr = 0;
        for (int c = 0; c < 8; c++) begin
            step(g);
            if (g && ngr < 3) begin
                gcyc[ngr] = c;
                ngr++;
                d_addr = d_addr + 9'd1;
                if (ngr == 3) d_req = 1'b0;
            end
        end
        check("b2b_count", 64'(ngr), 64'(3));
        check("b2b_gnt0", 64'(gcyc[0]), 64'(1));
        check("b2b_gnt1", 64'(gcyc[1]), 64'(3));
        check("b2b_gnt2", 64'(gcyc[2]), 64'(5));

        // short debug request under continuous pipeline writes, then withdrawn
        p_wr = 1'b1; p_addr = 9'h050;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h051;
        ngr = 0;
        for (int c = 0; c < 3; c++) begin
            p_wdata = $urandom;
            step(g);
            if (g) ngr++;
        end
        d_req = 1'b0;
        step(g);
        step(g);
        check("withdraw_no_gnt", 64'(ngr), 64'(0));
        check("withdraw_starve0", 64'(dbg_starve_cnt), 64'(0));
        set_idle();
        step(g);

        // randomized traffic
        g = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(g && (p_rd | p_wr))) begin
                op      = $urandom_range(0, 2);
                p_rd    = (op == 1);
                p_wr    = (op == 2);
                p_addr  = 9'($urandom_range(0, 15));
                p_wdata = $urandom;
                p_func3 = 3'($urandom_range(0, 7));
            end
            if (d_req && g) begin
                d_req = 1'b0;
            end else if (d_req && $urandom_range(0, 19) == 0) begin
                d_req = 1'b0;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            step(g);
        end
        set_idle();
        step(g);
        step(g);

        // reset asserted in the middle of a debug read cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h060;
        step(g);
        p_rd = 1'b1; p_addr = 9'h061;
        #2;
        check("abort_pre_gnt", 64'(d_gnt), 64'(1));
        check("abort_pre_stall", 64'(p_stall), 64'(1));
        reset = 1'b0;
        #1;
        check("abort_gnt", 64'(d_gnt), 64'(0));
        check("abort_rvalid", 64'(d_rvalid), 64'(0));
        check("abort_stall", 64'(p_stall), 64'(0));
        check("abort_m_rd", 64'(m_rd), 64'(1));
        check("abort_m_addr", 64'(m_addr), 64'(9'h061));
        check("abort_d_rdata", 64'(d_rdata), 64'(0));
        d_req = 1'b0;
        p_rd  = 1'b0;
        @(posedge clk);
        #3;
        check("abort_rvalid_held", 64'(d_rvalid), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step(g);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
